// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// parity-sense constants and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam bit ParityEven = 1'b0;
    localparam bit ParityOdd  = 1'b1;

    // Clock cycles occupied by one frame, start bit through the last stop bit.
    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits,
                                              input int unsigned clks_per_bit);
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous
// clear and a tick flagging the final cycle of each bit period.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rts_n,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at the end of the bit period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rts_n) begin
        if (!i_rts_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_tick = (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage for the byte FIFO: pops one word when allowed and serialises it
// as start bit, data LSB first, optional parity, then one or two stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = ParityEven,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rts_n,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_pop,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
    localparam logic [BitCntW-1:0] LastDataBit = BitCntW'(DATA_WIDTH - 1);
    localparam logic [BitCntW-1:0] LastStopBit = BitCntW'(STOP_BITS - 1);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BitCntW-1:0]    bit_cnt_q;
    logic                  parity_q;
    logic                  tx_q;
    logic                  bit_tick;
    logic                  start_ok;
    logic                  last_stop;

    assign start_ok   = i_enable & ~i_fifo_empty;
    assign shift_next = shift_q >> 1;
    assign last_stop  = (bit_cnt_q == LastStopBit);

    // Baud counter restarts as the start bit begins so bit edges align to the frame.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_clk     (i_clk),
        .i_rts_n   (i_rts_n),
        .i_clear   (state_q == StLoad),
        .o_bit_tick(bit_tick)
    );

    // Frame FSM with shift register, bit counter, parity accumulator and line driver.
    always_ff @(posedge i_clk or negedge i_rts_n) begin
        if (!i_rts_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q <= StPop;
                    end
                end
                StPop: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    // FIFO data is valid this cycle, one cycle after the pop.
                    shift_q   <= i_fifo_data;
                    parity_q  <= PARITY_ODD;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= StStart;
                end
                StStart: begin
                    if (bit_tick) begin
                        tx_q     <= shift_q[0];
                        parity_q <= parity_q ^ shift_q[0];
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == LastDataBit) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_next;
                            tx_q      <= shift_next[0];
                            parity_q  <= parity_q ^ shift_next[0];
                        end
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            bit_cnt_q <= '0;
                            state_q   <= start_ok ? StPop : StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx         = tx_q;
    assign o_fifo_pop   = (state_q == StPop);
    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = (state_q == StStop) & bit_tick & last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (8N1, 8E2, 8O1) at 4 clocks per bit,
// each fed by a depth-8 FIFO model; a monitor checks every frame cycle by cycle
// against a queue of hand-written expected frames.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int Cpb   = 4;
    localparam int Depth = 8;

    typedef struct {
        logic [11:0] bits;   // bit i is the i-th bit on the line
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en = 3'b000;
    logic [2:0] empty = 3'b111;
    logic [2:0] pop, tx, busy, done;
    logic [7:0] fdata [3];
    logic [2:0] push_req = 3'b000;
    logic [7:0] push_data [3];

    frame_t     exp_q [3][$];
    logic [7:0] fifo_q [3][$];
    frame_t     cur [3];
    logic [11:0] act [3];
    bit         in_frm [3];
    int         cyc [3], errs [3], gap [3], last_gap [3], frames [3], pops [3];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0),
                   .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_rts_n(rst_n), .i_enable(en[0]), .i_fifo_empty(empty[0]),
        .o_fifo_pop(pop[0]), .i_fifo_data(fdata[0]), .o_tx(tx[0]), .o_busy(busy[0]),
        .o_frame_done(done[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1),
                   .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut1 (
        .i_clk(clk), .i_rts_n(rst_n), .i_enable(en[1]), .i_fifo_empty(empty[1]),
        .o_fifo_pop(pop[1]), .i_fifo_data(fdata[1]), .o_tx(tx[1]), .o_busy(busy[1]),
        .o_frame_done(done[1]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1),
                   .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
        .i_clk(clk), .i_rts_n(rst_n), .i_enable(en[2]), .i_fifo_empty(empty[2]),
        .o_fifo_pop(pop[2]), .i_fifo_data(fdata[2]), .o_tx(tx[2]), .o_busy(busy[2]),
        .o_frame_done(done[2]));

    task automatic check(input string name, input int actual, input int want);
        total++;
        if (actual != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, actual, want);
        end
    endtask

    // FIFO model: registered read data valid the cycle after a pop.
    task automatic fifo_model();
        forever begin
            @(posedge clk or negedge rst_n);
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    fifo_q[g].delete();
                    empty[g] <= 1'b1;
                    fdata[g] <= 8'h00;
                    continue;
                end
                if (pop[g]) begin
                    pops[g]++;
                    if (fifo_q[g].size() > 0) fdata[g] <= fifo_q[g].pop_front();
                end
                if (push_req[g]) begin
                    if (fifo_q[g].size() >= Depth) begin
                        total++;
                        bad++;
                        $display("FAIL fifo%0d overflow: got %0d words, want <= %0d",
                                 g, fifo_q[g].size() + 1, Depth);
                    end else begin
                        fifo_q[g].push_back(push_data[g]);
                    end
                end
                empty[g] <= (fifo_q[g].size() == 0);
            end
        end
    endtask

    // Frame monitor: compares line level and done pulse on every cycle of a frame.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    in_frm[g] = 1'b0;
                    gap[g]    = 0;
                    continue;
                end
                if (pop[g] && empty[g]) begin
                    total++;
                    bad++;
                    $display("FAIL pop%0d while empty: got pop=1, want 0", g);
                end
                if (!in_frm[g]) begin
                    if (tx[g] == 1'b0) begin
                        if (exp_q[g].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL dut%0d unexpected frame: got start bit, want idle", g);
                            in_frm[g] = 1'b1;
                            cur[g].bits  = 12'hFFF;
                            cur[g].nbits = 10;
                        end else begin
                            cur[g]    = exp_q[g].pop_front();
                            in_frm[g] = 1'b1;
                        end
                        cyc[g]      = 0;
                        errs[g]     = 0;
                        act[g]      = '0;
                        last_gap[g] = gap[g];
                    end else begin
                        gap[g]++;
                        if (done[g]) begin
                            total++;
                            bad++;
                            $display("FAIL dut%0d done outside frame: got 1, want 0", g);
                        end
                    end
                end
                if (in_frm[g]) begin
                    if (tx[g] !== cur[g].bits[cyc[g] / Cpb]) errs[g]++;
                    if (done[g] !== (cyc[g] == cur[g].nbits * Cpb - 1)) errs[g]++;
                    if (cyc[g] % Cpb == 1) act[g][cyc[g] / Cpb] = tx[g];
                    cyc[g]++;
                    if (cyc[g] == cur[g].nbits * Cpb) begin
                        total++;
                        if (errs[g] != 0) begin
                            bad++;
                            $display("FAIL dut%0d frame: got bits=%03h errs=%0d, want bits=%03h",
                                     g, act[g], errs[g], cur[g].bits);
                        end
                        in_frm[g] = 1'b0;
                        gap[g]    = 0;
                        frames[g]++;
                    end
                end
            end
        end
    endtask

    task automatic push(input int g, input logic [7:0] d, input logic [11:0] bits,
                        input int nbits, input bit expect_frame);
        frame_t f;
        @(negedge clk);
        push_req[g]  = 1'b1;
        push_data[g] = d;
        if (expect_frame) begin
            f.bits  = bits;
            f.nbits = nbits;
            exp_q[g].push_back(f);
        end
        @(negedge clk);
        push_req[g] = 1'b0;
    endtask

    task automatic expect_frame(input int g, input logic [11:0] bits, input int nbits);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        exp_q[g].push_back(f);
    endtask

    task automatic wait_idle(input int g, input int limit, input string name);
        int n = 0;
        while ((exp_q[g].size() != 0 || in_frm[g] || busy[g] || !empty[g]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain in time"}, int'(n < limit), 1);
    endtask

    task automatic wait_tx_low(input int g, input int limit, input string name);
        int n = 0;
        while (tx[g] !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " start bit in time"}, int'(n < limit), 1);
    endtask

    initial begin
        logic [7:0] fill [8];
        int         p0, f0;
        bit         low_seen;
        int         lim8n1;
        fill   = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'hFE, 8'h7F};
        lim8n1 = int'(frame_len(8, 0, 1, Cpb)) + 20;

        fork
            fifo_model();
            monitor();
        join_none

        // Reset held for 5 cycles.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset tx", int'(tx), 7);
        check("reset pop", int'(pop), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst_n = 1'b1;

        // Single 8N1 frame of 0xA5: 0,1,0,1,0,0,1,0,1,1.
        en[0] = 1'b1;
        push(0, 8'hA5, 12'h34A, 10, 1'b1);
        wait_idle(0, lim8n1, "a5");
        check("a5 pops", pops[0], 1);
        check("a5 frames", frames[0], 1);
        check("a5 busy after", int'(busy[0]), 0);

        // Back-to-back 0x00 then 0xFF with a two-cycle idle gap.
        push(0, 8'h00, 12'h200, 10, 1'b1);
        push(0, 8'hFF, 12'h3FE, 10, 1'b1);
        wait_idle(0, 2 * lim8n1, "b2b");
        check("b2b pops", pops[0], 3);
        check("b2b gap", last_gap[0], 2);

        // Parity: 0x07 even/2 stop -> parity 1; 0x07 odd -> parity 0.
        en[1] = 1'b1;
        en[2] = 1'b1;
        push(1, 8'h07, 12'hE0E, 12, 1'b1);
        push(2, 8'h07, 12'h40E, 11, 1'b1);
        wait_idle(1, 80, "par even 07");
        wait_idle(2, 80, "par odd 07");
        // 0x03 even -> parity 0; 0xFF odd -> parity 1.
        push(1, 8'h03, 12'hC06, 12, 1'b1);
        push(2, 8'hFF, 12'h7FE, 11, 1'b1);
        wait_idle(1, 80, "par even 03");
        wait_idle(2, 80, "par odd ff");
        check("par pops dut1", pops[1], 2);
        check("par pops dut2", pops[2], 2);

        // Empty FIFO with enable: no pop, line stays high.
        p0       = pops[0];
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) low_seen = 1'b1;
        end
        check("empty no pop", pops[0], p0);
        check("empty tx high", int'(low_seen), 0);

        // Non-empty FIFO with enable low: no pop.
        en[0] = 1'b0;
        push(0, 8'h3C, 12'h278, 10, 1'b1);
        repeat (50) @(negedge clk);
        check("disabled no pop", pops[0], p0);

        // Drop enable mid-frame: frame completes, next word stays queued.
        en[0] = 1'b1;
        wait_tx_low(0, 20, "drop en");
        en[0] = 1'b0;
        push(0, 8'h5A, 12'h0, 10, 1'b0);
        repeat (60) @(negedge clk);
        check("drop en one pop", pops[0], p0 + 1);
        check("drop en frame done", frames[0], 4);
        check("drop en word held", int'(empty[0]), 0);
        expect_frame(0, 12'h2B4, 10);
        en[0] = 1'b1;
        wait_idle(0, lim8n1, "held 5a");

        // Fill to 8 words while disabled, then drain in order.
        en[0] = 1'b0;
        p0    = pops[0];
        f0    = frames[0];
        for (int i = 0; i < 8; i++) begin
            push(0, fill[i], {2'b01, fill[i], 1'b0}, 10, 1'b1);
        end
        en[0] = 1'b1;
        wait_idle(0, 8 * lim8n1, "fill8");
        check("fill8 pops", pops[0], p0 + 8);
        check("fill8 frames", frames[0], f0 + 8);
        check("fill8 empty", int'(empty[0]), 1);
        check("fill8 idle", int'(busy[0]), 0);

        // Reset during DATA of 0x00: line returns high before any clock edge.
        push(0, 8'h00, 12'h200, 10, 1'b1);
        wait_tx_low(0, 20, "mid rst");
        repeat (6) @(negedge clk);
        check("mid rst tx before", int'(tx[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst tx", int'(tx[0]), 1);
        check("mid rst busy", int'(busy[0]), 0);
        check("mid rst done", int'(done[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after rst tx idle", int'(tx[0]), 1);
        check("leftover expectations", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
